id_pipe_stage: RTL and testbench

- Parametrised, registered successor of the MIPS32 decode stage.
- Decodes the logic/shift/immediate subset and resolves operands through NUM_FWD forwarding sources in priority order.
- Detects load-use hazards and inserts bubbles; the ID/EX pipeline register is built in and uses a valid/ready handshake.
- Sits between the IF/ID register and EX; EX consumes ex_* outputs directly.

---
 rtl/id_pipe_stage.sv | 343 ++++++++++++++++++++++++++++++++++
 tb/tb_id_pipe_stage.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_pipe_stage.sv
// -----------------------------------------------------------------------------
// id_pipe_stage
//
// MIPS32 instruction decode stage with a built-in ID/EX pipeline register.
// It decodes the logic / shift / logic-immediate subset and resolves each
// register operand through NUM_FWD forwarding sources. Source 0 is the
// youngest and has the highest priority. If the selected forwarding source
// is a load whose data has not yet arrived, the stage inserts bubbles. EX
// takes the ex_* outputs through a valid/ready handshake.
//
// Optional feature (macro ID_STALL_CNT_EN):
//   defined   : stall_cnt_o is a free-running 32-bit count of cycles in which
//               IF offered an instruction that ID could not accept.
//   undefined : stall_cnt_o is tied to zero.
//
// Ports:
//   clk, rst                    clock, asynchronous active-low reset
//   if_valid_i, pc_i, inst_i    instruction from the IF/ID register
//   id_ready_o                  instruction accepted this cycle
//   reg{1,2}_read_o/addr_o      register-file read enables and addresses
//   reg{1,2}_data_i             register-file read data
//   fwd_wreg_i/wd_i/wdata_i     forwarding sources (packed, source 0 in LSBs)
//   fwd_pending_i               source data not yet valid (load in flight)
//   flush_i                     drop stage contents and current input
//   ex_ready_i                  EX consumes ex_* this cycle
//   ex_*                        registered decoded instruction for EX
//   stall_cnt_o                 stall cycle counter
// -----------------------------------------------------------------------------
module id_pipe_stage #(
   parameter int DATA_W   = 32,
   parameter int RADDR_W  = 5,
   parameter int NUM_FWD  = 2,
   parameter int ALUOP_W  = 8,
   parameter int ALUSEL_W = 3
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        if_valid_i,
   input  logic [31:0]                 pc_i,
   input  logic [31:0]                 inst_i,
   output logic                        id_ready_o,
   output logic                        reg1_read_o,
   output logic                        reg2_read_o,
   output logic [RADDR_W-1:0]          reg1_addr_o,
   output logic [RADDR_W-1:0]          reg2_addr_o,
   input  logic [DATA_W-1:0]           reg1_data_i,
   input  logic [DATA_W-1:0]           reg2_data_i,
   input  logic [NUM_FWD-1:0]          fwd_wreg_i,
   input  logic [NUM_FWD*RADDR_W-1:0]  fwd_wd_i,
   input  logic [NUM_FWD*DATA_W-1:0]   fwd_wdata_i,
   input  logic [NUM_FWD-1:0]          fwd_pending_i,
   input  logic                        flush_i,
   input  logic                        ex_ready_i,
   output logic                        ex_valid_o,
   output logic [31:0]                 ex_pc_o,
   output logic [ALUOP_W-1:0]          ex_aluop_o,
   output logic [ALUSEL_W-1:0]         ex_alusel_o,
   output logic [DATA_W-1:0]           ex_reg1_o,
   output logic [DATA_W-1:0]           ex_reg2_o,
   output logic [RADDR_W-1:0]          ex_wd_o,
   output logic                        ex_wreg_o,
   output logic                        ex_inst_invalid_o,
   output logic [31:0]                 stall_cnt_o
);

   // Primary opcodes
   localparam logic [5:0] OP_SPECIAL = 6'b000000;
   localparam logic [5:0] OP_ANDI    = 6'b001100;
   localparam logic [5:0] OP_ORI     = 6'b001101;
   localparam logic [5:0] OP_XORI    = 6'b001110;
   localparam logic [5:0] OP_LUI     = 6'b001111;
   localparam logic [5:0] OP_PREF    = 6'b110011;

   // SPECIAL function codes
   localparam logic [5:0] FN_SLL  = 6'b000000;
   localparam logic [5:0] FN_SRL  = 6'b000010;
   localparam logic [5:0] FN_SRA  = 6'b000011;
   localparam logic [5:0] FN_SLLV = 6'b000100;
   localparam logic [5:0] FN_SRLV = 6'b000110;
   localparam logic [5:0] FN_SRAV = 6'b000111;
   localparam logic [5:0] FN_SYNC = 6'b001111;
   localparam logic [5:0] FN_AND  = 6'b100100;
   localparam logic [5:0] FN_OR   = 6'b100101;
   localparam logic [5:0] FN_XOR  = 6'b100110;
   localparam logic [5:0] FN_NOR  = 6'b100111;

   // EX operation codes
   localparam logic [ALUOP_W-1:0]  EXE_NOP_OP    = ALUOP_W'(8'b0000_0000);
   localparam logic [ALUOP_W-1:0]  EXE_AND_OP    = ALUOP_W'(8'b0010_0100);
   localparam logic [ALUOP_W-1:0]  EXE_OR_OP     = ALUOP_W'(8'b0010_0101);
   localparam logic [ALUOP_W-1:0]  EXE_XOR_OP    = ALUOP_W'(8'b0010_0110);
   localparam logic [ALUOP_W-1:0]  EXE_NOR_OP    = ALUOP_W'(8'b0010_0111);
   localparam logic [ALUOP_W-1:0]  EXE_SLL_OP    = ALUOP_W'(8'b0111_1100);
   localparam logic [ALUOP_W-1:0]  EXE_SRL_OP    = ALUOP_W'(8'b0000_0010);
   localparam logic [ALUOP_W-1:0]  EXE_SRA_OP    = ALUOP_W'(8'b0000_0011);
   localparam logic [ALUSEL_W-1:0] EXE_RES_NOP   = ALUSEL_W'(3'b000);
   localparam logic [ALUSEL_W-1:0] EXE_RES_LOGIC = ALUSEL_W'(3'b001);
   localparam logic [ALUSEL_W-1:0] EXE_RES_SHIFT = ALUSEL_W'(3'b010);

   typedef struct packed {
      logic              hit;
      logic              pend;
      logic [DATA_W-1:0] data;
   } fwd_sel_t;

   typedef struct packed {
      logic              haz;
      logic [DATA_W-1:0] data;
   } opnd_t;

   // Maps a SPECIAL function code to its EX operation and result class.
   // The variable shifts share the operation code of the immediate shifts.
   function automatic logic [ALUOP_W+ALUSEL_W-1:0] special_map(input logic [5:0] fn);
      logic [ALUOP_W+ALUSEL_W-1:0] r;
      case (fn)
         FN_AND:          r = {EXE_AND_OP, EXE_RES_LOGIC};
         FN_OR:           r = {EXE_OR_OP,  EXE_RES_LOGIC};
         FN_XOR:          r = {EXE_XOR_OP, EXE_RES_LOGIC};
         FN_NOR:          r = {EXE_NOR_OP, EXE_RES_LOGIC};
         FN_SLL, FN_SLLV: r = {EXE_SLL_OP, EXE_RES_SHIFT};
         FN_SRL, FN_SRLV: r = {EXE_SRL_OP, EXE_RES_SHIFT};
         FN_SRA, FN_SRAV: r = {EXE_SRA_OP, EXE_RES_SHIFT};
         default:         r = {EXE_NOP_OP, EXE_RES_NOP};
      endcase
      return r;
   endfunction

   // Finds the youngest writing source for addr. It scans from the oldest
   // source to the youngest so that the lowest index overwrites older hits.
   function automatic fwd_sel_t fwd_lookup(
      input logic [RADDR_W-1:0]         addr,
      input logic [NUM_FWD-1:0]         wreg,
      input logic [NUM_FWD*RADDR_W-1:0] wd,
      input logic [NUM_FWD*DATA_W-1:0]  wdata,
      input logic [NUM_FWD-1:0]         pend
   );
      fwd_sel_t sel;
      sel = '0;
      for (int i = NUM_FWD - 1; i >= 0; i--) begin
         if (wreg[i] && (wd[i*RADDR_W +: RADDR_W] == addr)) begin
            sel.hit  = 1'b1;
            sel.pend = pend[i];
            sel.data = wdata[i*DATA_W +: DATA_W];
         end
      end
      return sel;
   endfunction

   // Chooses the operand for one read port. An unread port takes the
   // immediate. r0 always reads as zero and is never forwarded.
   function automatic opnd_t operand(
      input logic               rd,
      input logic [RADDR_W-1:0] addr,
      input logic [DATA_W-1:0]  imm,
      input logic [DATA_W-1:0]  rf,
      input fwd_sel_t           sel
   );
      opnd_t o;
      o = '0;
      if (!rd) begin
         o.data = imm;
      end else if (addr == '0) begin
         o.data = '0;
      end else if (sel.hit) begin
         o.data = sel.data;
         o.haz  = sel.pend;
      end else begin
         o.data = rf;
      end
      return o;
   endfunction

   logic [5:0]          op_s, fn_s;
   logic [4:0]          rs_s, rt_s, rd_s, sa_s;
   logic [15:0]         imm16_s;
   logic [ALUOP_W-1:0]  dec_aluop_s;
   logic [ALUSEL_W-1:0] dec_alusel_s;
   logic                dec_wreg_s, dec_rd1_s, dec_rd2_s, dec_invalid_s;
   logic [RADDR_W-1:0]  dec_wd_s, reg1_addr_s, reg2_addr_s;
   logic [31:0]         dec_imm_s;
   logic [DATA_W-1:0]   imm_s;
   fwd_sel_t            sel1_s, sel2_s;
   opnd_t               opnd1_s, opnd2_s;
   logic                hazard_s, adv_s, id_ready_s;

   logic                ex_valid_r, ex_wreg_r, ex_invalid_r;
   logic [31:0]         ex_pc_r;
   logic [ALUOP_W-1:0]  ex_aluop_r;
   logic [ALUSEL_W-1:0] ex_alusel_r;
   logic [DATA_W-1:0]   ex_reg1_r, ex_reg2_r;
   logic [RADDR_W-1:0]  ex_wd_r;

   assign op_s        = inst_i[31:26];
   assign rs_s        = inst_i[25:21];
   assign rt_s        = inst_i[20:16];
   assign rd_s        = inst_i[15:11];
   assign sa_s        = inst_i[10:6];
   assign fn_s        = inst_i[5:0];
   assign imm16_s     = inst_i[15:0];
   assign reg1_addr_s = RADDR_W'(rs_s);
   assign reg2_addr_s = RADDR_W'(rt_s);
   assign imm_s       = DATA_W'(dec_imm_s);

   // Instruction decode: operation, operand sources, destination, validity.
   always_comb begin
      dec_aluop_s   = EXE_NOP_OP;
      dec_alusel_s  = EXE_RES_NOP;
      dec_wreg_s    = 1'b0;
      dec_wd_s      = RADDR_W'(rd_s);
      dec_rd1_s     = 1'b0;
      dec_rd2_s     = 1'b0;
      dec_imm_s     = 32'h0000_0000;
      dec_invalid_s = 1'b1;
      case (op_s)
         OP_SPECIAL: begin
            {dec_aluop_s, dec_alusel_s} = special_map(fn_s);
            if ((sa_s == 5'd0) && (fn_s inside {FN_OR, FN_AND, FN_XOR, FN_NOR,
                                                FN_SLLV, FN_SRLV, FN_SRAV})) begin
               dec_wreg_s    = 1'b1;
               dec_rd1_s     = 1'b1;
               dec_rd2_s     = 1'b1;
               dec_invalid_s = 1'b0;
            end else if ((rs_s == 5'd0) && (fn_s inside {FN_SLL, FN_SRL, FN_SRA})) begin
               // Shift amount is carried to EX as operand 1.
               dec_wreg_s    = 1'b1;
               dec_rd2_s     = 1'b1;
               dec_imm_s     = {27'd0, sa_s};
               dec_invalid_s = 1'b0;
            end else if ((sa_s == 5'd0) && (fn_s == FN_SYNC)) begin
               dec_invalid_s = 1'b0;
            end else begin
               dec_aluop_s  = EXE_NOP_OP;
               dec_alusel_s = EXE_RES_NOP;
            end
         end
         OP_ORI, OP_ANDI, OP_XORI, OP_LUI: begin
            dec_wreg_s    = 1'b1;
            dec_wd_s      = RADDR_W'(rt_s);
            dec_rd1_s     = 1'b1;
            dec_alusel_s  = EXE_RES_LOGIC;
            dec_invalid_s = 1'b0;
            dec_imm_s     = {16'h0000, imm16_s};
            case (op_s)
               OP_ANDI: dec_aluop_s = EXE_AND_OP;
               OP_XORI: dec_aluop_s = EXE_XOR_OP;
               OP_LUI: begin
                  // rs OR (imm << 16); rs is r0 in well-formed code.
                  dec_aluop_s = EXE_OR_OP;
                  dec_imm_s   = {imm16_s, 16'h0000};
               end
               default: dec_aluop_s = EXE_OR_OP;
            endcase
         end
         OP_PREF: dec_invalid_s = 1'b0;
         default: dec_invalid_s = 1'b1;
      endcase
   end

   // Operand resolution and load-use hazard detection on both read ports.
   always_comb begin
      sel1_s   = fwd_lookup(reg1_addr_s, fwd_wreg_i, fwd_wd_i, fwd_wdata_i, fwd_pending_i);
      sel2_s   = fwd_lookup(reg2_addr_s, fwd_wreg_i, fwd_wd_i, fwd_wdata_i, fwd_pending_i);
      opnd1_s  = operand(dec_rd1_s, reg1_addr_s, imm_s, reg1_data_i, sel1_s);
      opnd2_s  = operand(dec_rd2_s, reg2_addr_s, imm_s, reg2_data_i, sel2_s);
      hazard_s = opnd1_s.haz || opnd2_s.haz;
   end

   assign adv_s       = !ex_valid_r || ex_ready_i;
   assign id_ready_s  = adv_s && !hazard_s;
   assign id_ready_o  = id_ready_s;
   assign reg1_read_o = dec_rd1_s;
   assign reg2_read_o = dec_rd2_s;
   assign reg1_addr_o = reg1_addr_s;
   assign reg2_addr_o = reg2_addr_s;

   // ID/EX register. Priority: flush, accept, bubble, hold.
   // A flush clears only valid and write-enable. The payload fields are
   // don't-care while ex_valid_o is low.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ex_valid_r   <= 1'b0;
         ex_pc_r      <= 32'h0000_0000;
         ex_aluop_r   <= EXE_NOP_OP;
         ex_alusel_r  <= EXE_RES_NOP;
         ex_reg1_r    <= '0;
         ex_reg2_r    <= '0;
         ex_wd_r      <= '0;
         ex_wreg_r    <= 1'b0;
         ex_invalid_r <= 1'b0;
      end else if (flush_i) begin
         ex_valid_r <= 1'b0;
         ex_wreg_r  <= 1'b0;
      end else if (id_ready_s && if_valid_i) begin
         ex_valid_r   <= 1'b1;
         ex_pc_r      <= pc_i;
         ex_aluop_r   <= dec_aluop_s;
         ex_alusel_r  <= dec_alusel_s;
         ex_reg1_r    <= opnd1_s.data;
         ex_reg2_r    <= opnd2_s.data;
         ex_wd_r      <= dec_wd_s;
         ex_wreg_r    <= dec_wreg_s;
         ex_invalid_r <= dec_invalid_s;
      end else if (adv_s) begin
         ex_valid_r  <= 1'b0;
         ex_wreg_r   <= 1'b0;
         ex_aluop_r  <= EXE_NOP_OP;
         ex_alusel_r <= EXE_RES_NOP;
      end else begin
         // EX is back-pressuring: keep the issued instruction untouched.
         ex_valid_r <= ex_valid_r;
      end
   end

   assign ex_valid_o        = ex_valid_r;
   assign ex_pc_o           = ex_pc_r;
   assign ex_aluop_o        = ex_aluop_r;
   assign ex_alusel_o       = ex_alusel_r;
   assign ex_reg1_o         = ex_reg1_r;
   assign ex_reg2_o         = ex_reg2_r;
   assign ex_wd_o           = ex_wd_r;
   assign ex_wreg_o         = ex_wreg_r;
   assign ex_inst_invalid_o = ex_invalid_r;

`ifdef ID_STALL_CNT_EN
   logic [31:0] stall_cnt_r;

   // Stall counter: IF offers an instruction that ID refuses (not flushed).
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cnt_r <= 32'd0;
      end else if (if_valid_i && !id_ready_s && !flush_i) begin
         stall_cnt_r <= stall_cnt_r + 32'd1;
      end else begin
         stall_cnt_r <= stall_cnt_r;
      end
   end

   assign stall_cnt_o = stall_cnt_r;
`else
   assign stall_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_id_pipe_stage.sv
// -----------------------------------------------------------------------------
// tb_id_pipe_stage
//
// Directed steps followed by randomized traffic against id_pipe_stage.
// Expected values come from a reference model derived from the instruction
// rules, the forwarding priority and the handshake rules.
// -----------------------------------------------------------------------------
module tb_id_pipe_stage;
   localparam int DW = 32;
   localparam int AW = 5;
   localparam int NF = 2;

   logic           clk = 1'b0;
   logic           rst;
   logic           if_valid_i;
   logic [31:0]    pc_i, inst_i;
   logic           id_ready_o, reg1_read_o, reg2_read_o;
   logic [AW-1:0]  reg1_addr_o, reg2_addr_o;
   logic [DW-1:0]  reg1_data_i, reg2_data_i;
   logic [NF-1:0]  fwd_wreg_i, fwd_pending_i;
   logic [NF*AW-1:0] fwd_wd_i;
   logic [NF*DW-1:0] fwd_wdata_i;
   logic           flush_i, ex_ready_i, ex_valid_o, ex_wreg_o, ex_inst_invalid_o;
   logic [31:0]    ex_pc_o, stall_cnt_o;
   logic [7:0]     ex_aluop_o;
   logic [2:0]     ex_alusel_o;
   logic [DW-1:0]  ex_reg1_o, ex_reg2_o;
   logic [AW-1:0]  ex_wd_o;

   always #5 clk = ~clk;

   id_pipe_stage #(.DATA_W(DW), .RADDR_W(AW), .NUM_FWD(NF), .ALUOP_W(8), .ALUSEL_W(3)) dut (
      .clk(clk), .rst(rst), .if_valid_i(if_valid_i), .pc_i(pc_i), .inst_i(inst_i),
      .id_ready_o(id_ready_o), .reg1_read_o(reg1_read_o), .reg2_read_o(reg2_read_o),
      .reg1_addr_o(reg1_addr_o), .reg2_addr_o(reg2_addr_o),
      .reg1_data_i(reg1_data_i), .reg2_data_i(reg2_data_i),
      .fwd_wreg_i(fwd_wreg_i), .fwd_wd_i(fwd_wd_i), .fwd_wdata_i(fwd_wdata_i),
      .fwd_pending_i(fwd_pending_i), .flush_i(flush_i), .ex_ready_i(ex_ready_i),
      .ex_valid_o(ex_valid_o), .ex_pc_o(ex_pc_o), .ex_aluop_o(ex_aluop_o),
      .ex_alusel_o(ex_alusel_o), .ex_reg1_o(ex_reg1_o), .ex_reg2_o(ex_reg2_o),
      .ex_wd_o(ex_wd_o), .ex_wreg_o(ex_wreg_o), .ex_inst_invalid_o(ex_inst_invalid_o),
      .stall_cnt_o(stall_cnt_o)
   );

   typedef struct packed {
      logic [7:0]  aluop;
      logic [2:0]  alusel;
      logic        wreg;
      logic [4:0]  wd;
      logic        invalid;
      logic        rd1;
      logic        rd2;
      logic [31:0] imm;
   } dec_t;

   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic [7:0]  aluop;
      logic [2:0]  alusel;
      logic [31:0] r1;
      logic [31:0] r2;
      logic [4:0]  wd;
      logic        wreg;
      logic        invalid;
   } st_t;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] rf [32];
   st_t         m;
   logic [31:0] m_cnt;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] exp_cnt();
`ifdef ID_STALL_CNT_EN
      return m_cnt;
`else
      return 32'd0;
`endif
   endfunction

   // Reference decode written from the instruction table.
   function automatic dec_t ref_decode(input logic [31:0] w);
      dec_t d;
      logic [5:0] op, fn;
      logic [4:0] rs, rt, rd, sa;
      op = w[31:26]; rs = w[25:21]; rt = w[20:16]; rd = w[15:11]; sa = w[10:6]; fn = w[5:0];
      d = '0;
      d.wd = rd;
      d.invalid = 1'b1;
      if (op == 6'h00 && sa == 5'd0 && (fn inside {6'h24, 6'h25, 6'h26, 6'h27})) begin
         d.aluop = {2'b00, fn}; d.alusel = 3'd1;
         d.rd1 = 1'b1; d.rd2 = 1'b1; d.wreg = 1'b1; d.invalid = 1'b0;
      end else if (op == 6'h00 && sa == 5'd0 && (fn inside {6'h04, 6'h06, 6'h07})) begin
         d.aluop = (fn == 6'h04) ? 8'h7C : {2'b00, fn - 6'h04};
         d.alusel = 3'd2; d.rd1 = 1'b1; d.rd2 = 1'b1; d.wreg = 1'b1; d.invalid = 1'b0;
      end else if (w[31:21] == 11'd0 && (fn inside {6'h00, 6'h02, 6'h03})) begin
         d.aluop = (fn == 6'h00) ? 8'h7C : {2'b00, fn};
         d.alusel = 3'd2; d.rd2 = 1'b1; d.imm = {27'd0, sa}; d.wreg = 1'b1; d.invalid = 1'b0;
      end else if (op == 6'h00 && sa == 5'd0 && fn == 6'h0F) begin
         d.invalid = 1'b0;
      end else if (op inside {6'h0C, 6'h0D, 6'h0E, 6'h0F}) begin
         d.aluop = (op == 6'h0C) ? 8'h24 : (op == 6'h0E) ? 8'h26 : 8'h25;
         d.alusel = 3'd1; d.rd1 = 1'b1; d.wreg = 1'b1; d.wd = rt; d.invalid = 1'b0;
         d.imm = (op == 6'h0F) ? {w[15:0], 16'h0} : {16'h0, w[15:0]};
      end else if (op == 6'h33) begin
         d.invalid = 1'b0;
      end
      return d;
   endfunction

   // Operand model: the first (youngest) matching source wins.
   task automatic ref_operand(input logic rd, input logic [4:0] a, input logic [31:0] imm,
                              input logic [31:0] rfd, output logic [31:0] v, output logic haz);
      v = rfd;
      haz = 1'b0;
      if (!rd) begin
         v = imm;
      end else if (a == 5'd0) begin
         v = 32'd0;
      end else begin
         for (int i = 0; i < NF; i++) begin
            if (fwd_wreg_i[i] && fwd_wd_i[i*AW +: AW] == a) begin
               v = fwd_wdata_i[i*DW +: DW];
               haz = fwd_pending_i[i];
               break;
            end
         end
      end
   endtask

   task automatic present(input logic v, input logic [31:0] pc, input logic [31:0] w);
      if_valid_i = v;
      pc_i = pc;
      inst_i = w;
      reg1_data_i = rf[w[25:21]];
      reg2_data_i = rf[w[20:16]];
   endtask

   task automatic set_src(input int i, input logic we, input logic [4:0] wd,
                          input logic [31:0] d, input logic p);
      fwd_wreg_i[i] = we;
      fwd_wd_i[i*AW +: AW] = wd;
      fwd_wdata_i[i*DW +: DW] = d;
      fwd_pending_i[i] = p;
   endtask

   task automatic check_outputs(input string tag);
      chk({tag, ".valid"},   {31'd0, ex_valid_o}, {31'd0, m.valid});
      chk({tag, ".pc"},      ex_pc_o, m.pc);
      chk({tag, ".aluop"},   {24'd0, ex_aluop_o}, {24'd0, m.aluop});
      chk({tag, ".alusel"},  {29'd0, ex_alusel_o}, {29'd0, m.alusel});
      chk({tag, ".reg1"},    ex_reg1_o, m.r1);
      chk({tag, ".reg2"},    ex_reg2_o, m.r2);
      chk({tag, ".wd"},      {27'd0, ex_wd_o}, {27'd0, m.wd});
      chk({tag, ".wreg"},    {31'd0, ex_wreg_o}, {31'd0, m.wreg});
      chk({tag, ".invalid"}, {31'd0, ex_inst_invalid_o}, {31'd0, m.invalid});
      chk({tag, ".stall"},   stall_cnt_o, exp_cnt());
   endtask

   // One clock: check the combinational outputs, advance the model,
   // clock the DUT, and compare the registered outputs.
   task automatic step(input string tag);
      dec_t d;
      logic [31:0] v1, v2;
      logic h1, h2, adv, rdy;
      #1;
      d = ref_decode(inst_i);
      ref_operand(d.rd1, inst_i[25:21], d.imm, reg1_data_i, v1, h1);
      ref_operand(d.rd2, inst_i[20:16], d.imm, reg2_data_i, v2, h2);
      adv = !m.valid || ex_ready_i;
      rdy = adv && !(h1 || h2);
      chk({tag, ".id_ready"}, {31'd0, id_ready_o}, {31'd0, rdy});
      chk({tag, ".rd1"}, {31'd0, reg1_read_o}, {31'd0, d.rd1});
      chk({tag, ".rd2"}, {31'd0, reg2_read_o}, {31'd0, d.rd2});
      chk({tag, ".a1"}, {27'd0, reg1_addr_o}, {27'd0, inst_i[25:21]});
      chk({tag, ".a2"}, {27'd0, reg2_addr_o}, {27'd0, inst_i[20:16]});
      if (if_valid_i && !rdy && !flush_i) m_cnt = m_cnt + 32'd1;
      if (flush_i) begin
         m.valid = 1'b0; m.wreg = 1'b0;
      end else if (rdy && if_valid_i) begin
         m = '{valid: 1'b1, pc: pc_i, aluop: d.aluop, alusel: d.alusel, r1: v1, r2: v2,
               wd: d.wd, wreg: d.wreg, invalid: d.invalid};
      end else if (adv) begin
         m.valid = 1'b0; m.wreg = 1'b0; m.aluop = 8'h00; m.alusel = 3'd0;
      end
      @(posedge clk);
      #1;
      check_outputs(tag);
   endtask

   function automatic logic [31:0] rtype(input logic [4:0] rs, rt, rd, sa, input logic [5:0] fn);
      return {6'h00, rs, rt, rd, sa, fn};
   endfunction

   function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs, rt,
                                         input logic [15:0] k);
      return {op, rs, rt, k};
   endfunction

   function automatic logic [31:0] rand_inst();
      logic [5:0] fns [8];
      logic [5:0] shf [3];
      logic [5:0] iops [4];
      logic [4:0] rs, rt, rd, sa;
      int k;
      fns  = '{6'h25, 6'h24, 6'h26, 6'h27, 6'h04, 6'h06, 6'h07, 6'h0F};
      shf  = '{6'h00, 6'h02, 6'h03};
      iops = '{6'h0D, 6'h0C, 6'h0E, 6'h0F};
      rs = 5'($urandom_range(0, 7));
      rt = 5'($urandom_range(0, 7));
      rd = 5'($urandom_range(0, 31));
      sa = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
      k = $urandom_range(0, 9);
      if (k < 3) return rtype(rs, rt, rd, sa, fns[$urandom_range(0, 7)]);
      if (k == 3) return rtype(($urandom_range(0, 3) == 0) ? rs : 5'd0, rt, rd,
                               5'($urandom_range(0, 31)), shf[$urandom_range(0, 2)]);
      if (k < 7) return itype(iops[$urandom_range(0, 3)], rs, rt, 16'($urandom));
      if (k == 7) return itype(6'h33, rs, rt, 16'($urandom));
      return $urandom;
   endfunction

   initial begin
      rst = 1'b0;
      for (int i = 0; i < 32; i++) rf[i] = $urandom;
      present(1'b0, 32'h0, 32'h0);
      fwd_wreg_i = '0; fwd_pending_i = '0; fwd_wd_i = '0; fwd_wdata_i = '0;
      flush_i = 1'b0; ex_ready_i = 1'b1;
      m = '0; m_cnt = 32'd0;
      @(posedge clk); @(posedge clk); #1;
      check_outputs("reset");
      rst = 1'b1;

      // 1: ORI r1,r0,0x1234 then OR r2,r1,r1
      present(1'b1, 32'h100, itype(6'h0D, 5'd0, 5'd1, 16'h1234));
      step("ori");
      chk("ori.reg2_const", ex_reg2_o, 32'h0000_1234);
      chk("ori.wd_const", {27'd0, ex_wd_o}, 32'd1);
      present(1'b1, 32'h104, rtype(5'd1, 5'd1, 5'd2, 5'd0, 6'h25));
      step("or");
      chk("or.aluop_const", {24'd0, ex_aluop_o}, 32'h25);
      chk("or.reg1_rf", ex_reg1_o, rf[1]);

      // 2: two sources for r3, the youngest wins; r0 is never forwarded
      set_src(0, 1'b1, 5'd3, 32'hAAAA_0000, 1'b0);
      set_src(1, 1'b1, 5'd3, 32'h0000_5555, 1'b0);
      present(1'b1, 32'h108, rtype(5'd3, 5'd3, 5'd4, 5'd0, 6'h24));
      step("fwd_prio");
      chk("fwd_prio.reg2_const", ex_reg2_o, 32'hAAAA_0000);
      set_src(0, 1'b1, 5'd0, 32'hAAAA_0000, 1'b0);
      set_src(1, 1'b1, 5'd0, 32'h0000_5555, 1'b0);
      present(1'b1, 32'h10C, rtype(5'd0, 5'd0, 5'd4, 5'd0, 6'h24));
      step("fwd_r0");
      chk("fwd_r0.reg1_const", ex_reg1_o, 32'd0);

      // 3: load-use hazard on r5, then the data arrives
      set_src(1, 1'b0, 5'd0, 32'd0, 1'b0);
      set_src(0, 1'b1, 5'd5, 32'hDEAD_BEEF, 1'b1);
      present(1'b1, 32'h110, rtype(5'd5, 5'd0, 5'd6, 5'd0, 6'h26));
      step("hazard");
      chk("hazard.bubble_const", {31'd0, ex_valid_o}, 32'd0);
      set_src(0, 1'b1, 5'd5, 32'h0000_0077, 1'b0);
      step("hazard_clear");
      chk("hazard_clear.reg1_const", ex_reg1_o, 32'h77);

      // 4: back-pressure for 3 cycles
      set_src(0, 1'b0, 5'd0, 32'd0, 1'b0);
      ex_ready_i = 1'b0;
      present(1'b1, 32'h114, itype(6'h0C, 5'd2, 5'd3, 16'h00FF));
      for (int i = 0; i < 3; i++) step("hold");
      chk("hold.pc_const", ex_pc_o, 32'h110);
      ex_ready_i = 1'b1;
      step("release");
      chk("release.pc_const", ex_pc_o, 32'h114);

      // 5: immediate shift and a reserved word
      present(1'b1, 32'h118, rtype(5'd0, 5'd8, 5'd7, 5'd4, 6'h00));
      step("sll");
      chk("sll.reg1_const", ex_reg1_o, 32'd4);
      present(1'b1, 32'h11C, 32'hFC00_0000);
      step("reserved");
      chk("reserved.invalid_const", {31'd0, ex_inst_invalid_o}, 32'd1);

      // 6: flush during hold, then an asynchronous reset mid-cycle
      ex_ready_i = 1'b0;
      present(1'b1, 32'h120, itype(6'h0F, 5'd0, 5'd9, 16'hBEEF));
      step("pre_flush");
      flush_i = 1'b1;
      step("flush");
      flush_i = 1'b0;
      ex_ready_i = 1'b1;
      step("post_flush");
      #3;
      rst = 1'b0;
      #1;
      m = '0; m_cnt = 32'd0;
      check_outputs("async_rst");
      @(posedge clk); #1;
      rst = 1'b1;

      // Randomized traffic
      for (int n = 0; n < 400; n++) begin
         for (int i = 0; i < NF; i++)
            set_src(i, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                    1'($urandom_range(0, 3) == 0));
         ex_ready_i = ($urandom_range(0, 3) != 0);
         flush_i = ($urandom_range(0, 15) == 0);
         present(1'($urandom_range(0, 7) != 0), $urandom, rand_inst());
         step("rand");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
